// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader and its neighbours
// (register file, trace datapath).
package reg_dump_reader_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } dump_state_e;

endpackage : reg_dump_reader_pkg

// File: rtl/reg_dump_reader_if.sv
// Valid/ready beat stream carrying (address, data, last) from the dump reader
// to the debug/trace consumer.
import reg_dump_reader_pkg::*;

interface reg_dump_reader_if #(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
);
    logic                  m_valid;
    logic                  m_ready;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    // Producer side (the dump reader).
    modport master (
        output m_valid,
        output m_addr,
        output m_data,
        output m_last,
        input  m_ready
    );

    // Consumer side (trace path).
    modport slave (
        input  m_valid,
        input  m_addr,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface : reg_dump_reader_if

// File: rtl/reg_dump_reader.sv
// Register-file dump reader: walks a wrapping address range over the register
// file's asynchronous read port and streams each (address, data) pair out as a
// valid/ready beat. One beat per FETCH/SEND pair, so at most one beat every two
// cycles; the data is captured in FETCH so later writes do not disturb a beat.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    reg_dump_reader_if.master     m_if,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    dump_state_e           state_r;
    dump_state_e           state_nxt_s;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [ADDR_WIDTH-1:0] end_r;
    logic                  abort_flag_r;
    logic                  m_valid_r;
    logic [ADDR_WIDTH-1:0] m_addr_r;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic                  m_last_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  handshake_s;
    logic                  abort_any_s;
    logic                  load_s;
    logic                  fetch_s;
    logic                  advance_s;
    logic                  finish_ok_s;

    assign handshake_s = m_valid_r & m_if.m_ready;
    // An abort raised during the final handshake cycle also suppresses done.
    assign abort_any_s = abort_flag_r | abort;

    // Next-state and control strobes for the dump sequencer.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        fetch_s     = 1'b0;
        advance_s   = 1'b0;
        finish_ok_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt_s = FETCH;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                    fetch_s     = 1'b1;
                end
            end
            SEND: begin
                if (handshake_s) begin
                    if (m_last_r || abort_any_s) begin
                        state_nxt_s = IDLE;
                        finish_ok_s = m_last_r & ~abort_any_s;
                    end else begin
                        state_nxt_s = FETCH;
                        advance_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Range pointer/end register and the sticky abort request for the beat in flight.
    always_ff @(posedge CLK) begin
        if (reset) begin
            ptr_r        <= '0;
            end_r        <= '0;
            abort_flag_r <= 1'b0;
        end else begin
            if (load_s) begin
                ptr_r <= first_addr;
                end_r <= last_addr;
            end else if (advance_s) begin
                ptr_r <= ptr_r + ADDR_ONE;
            end else begin
                ptr_r <= ptr_r;
            end
            if (state_nxt_s == SEND) begin
                abort_flag_r <= abort_flag_r | ((state_r == SEND) & abort);
            end else begin
                abort_flag_r <= 1'b0;
            end
        end
    end

    // Output beat registers: captured in FETCH, held stable until the handshake.
    always_ff @(posedge CLK) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_addr_r  <= '0;
            m_data_r  <= '0;
            m_last_r  <= 1'b0;
        end else if (fetch_s) begin
            m_valid_r <= 1'b1;
            m_addr_r  <= ptr_r;
            m_data_r  <= rf_data;
            m_last_r  <= (ptr_r == end_r);
        end else if (handshake_s) begin
            m_valid_r <= 1'b0;
            m_addr_r  <= m_addr_r;
            m_data_r  <= m_data_r;
            m_last_r  <= m_last_r;
        end else begin
            m_valid_r <= m_valid_r;
            m_addr_r  <= m_addr_r;
            m_data_r  <= m_data_r;
            m_last_r  <= m_last_r;
        end
    end

    // Status outputs: busy tracks the upcoming state, done pulses after a normal finish.
    always_ff @(posedge CLK) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= finish_ok_s;
        end
    end

    assign rf_addr        = ptr_r;
    assign m_if.m_valid   = m_valid_r;
    assign m_if.m_addr    = m_addr_r;
    assign m_if.m_data    = m_data_r;
    assign m_if.m_last    = m_last_r;
    assign busy           = busy_r;
    assign done           = done_r;

endmodule : reg_dump_reader

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a table of dump ranges with hand-computed
// beat counts, followed by hand-written sequences for stall, abort, write
// coherency and mid-dump reset.
`timescale 1ns/1ps
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    localparam int AW = REG_ADDR_WIDTH;
    localparam int DW = REG_DATA_WIDTH;

    logic          CLK = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          busy;
    logic          done;

    // Register-file model: asynchronous read, one synchronous write port.
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rf_mem  [0:31];
    logic [DW-1:0] exp_mem [0:31];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] first;
        logic [AW-1:0] last;
        int            beats;
        string         name;
    } vec_t;

    vec_t vecs [5];

    reg_dump_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

    reg_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .abort      (abort),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .m_if       (m_if),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (we) rf_mem[wa] <= wd;
    end

    assign rf_data = rf_mem[rf_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        we = 1'b1; wa = a; wd = d;
        @(negedge CLK);
        we = 1'b0;
        exp_mem[a] = d;
    endtask

    // Full dump with m_ready held high; checks every beat, timing of the last
    // handshake (2 cycles per beat from the accepted start) and the done pulse.
    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input int exp_beats, input string tag);
        int            beats;
        bit            fin;
        logic [AW-1:0] exp_a;
        beats = 0; fin = 1'b0; exp_a = f;
        @(negedge CLK);
        start = 1'b1; first_addr = f; last_addr = l; m_if.m_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            if (k > 0) @(negedge CLK);
            if (m_if.m_valid) begin
                check({tag, " addr"}, m_if.m_addr, exp_a);
                check({tag, " data"}, m_if.m_data, exp_mem[exp_a]);
                check({tag, " last"}, m_if.m_last, (beats == exp_beats - 1));
                beats++;
                exp_a = exp_a + 5'd1;
                if (m_if.m_last) begin
                    check({tag, " last-handshake cycle"}, k + 1, 2 * exp_beats);
                    fin = 1'b1;
                end
            end
        end
        check({tag, " finished in time"}, fin, 1'b1);
        check({tag, " beat count"}, beats, exp_beats);
        @(negedge CLK);
        check({tag, " done pulse"}, done, 1'b1);
        check({tag, " busy after"}, busy, 1'b0);
        @(negedge CLK);
        check({tag, " done one cycle"}, done, 1'b0);
    endtask

    initial begin
        bit found;
        bit bad;
        bit fin;
        bit wrote;

        vecs[0] = '{5'd0,  5'd31, 32, "full sweep"};
        vecs[1] = '{5'd30, 5'd1,  4,  "wrap 30..1"};
        vecs[2] = '{5'd5,  5'd5,  1,  "single 5"};
        vecs[3] = '{5'd31, 5'd0,  2,  "wrap 31..0"};
        vecs[4] = '{5'd10, 5'd13, 4,  "range 10..13"};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        first_addr = 5'd0; last_addr = 5'd0;
        we = 1'b0; wa = 5'd0; wd = 32'd0;
        m_if.m_ready = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset m_valid", m_if.m_valid, 1'b0);
        check("reset m_addr",  m_if.m_addr, 5'd0);
        check("reset m_data",  m_if.m_data, 32'd0);
        check("reset m_last",  m_if.m_last, 1'b0);
        check("reset busy",    busy, 1'b0);
        check("reset done",    done, 1'b0);
        check("reset rf_addr", rf_addr, 5'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) write_reg(i[AW-1:0], 32'h1000_0000 + i);

        // Table-driven ranges.
        for (int i = 0; i < 5; i++) run_dump(vecs[i].first, vecs[i].last, vecs[i].beats, vecs[i].name);

        // Back-pressure on a single beat; start held while busy must be ignored.
        @(negedge CLK);
        start = 1'b1; first_addr = 5'd5; last_addr = 5'd5; m_if.m_ready = 1'b0;
        @(negedge CLK);
        first_addr = 5'd20; last_addr = 5'd20;
        for (int n = 0; n < 10 && !m_if.m_valid; n++) @(negedge CLK);
        check("stall valid seen", m_if.m_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("stall valid held", m_if.m_valid, 1'b1);
            check("stall addr",       m_if.m_addr, 5'd5);
            check("stall data",       m_if.m_data, 32'h1000_0005);
            check("stall last",       m_if.m_last, 1'b1);
            @(negedge CLK);
        end
        start = 1'b0; m_if.m_ready = 1'b1;
        @(negedge CLK);
        check("stall valid dropped", m_if.m_valid, 1'b0);
        check("stall done",          done, 1'b1);
        // Start in the done cycle is accepted.
        start = 1'b1; first_addr = 5'd8; last_addr = 5'd8;
        @(negedge CLK);
        start = 1'b0;
        check("start in done cycle busy", busy, 1'b1);
        @(negedge CLK);
        check("start in done cycle valid", m_if.m_valid, 1'b1);
        check("start in done cycle addr",  m_if.m_addr, 5'd8);
        repeat (3) @(negedge CLK);

        // Abort in SEND on beat 3 while stalled.
        @(negedge CLK);
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd31; m_if.m_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        found = 1'b0; bad = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (m_if.m_valid && m_if.m_addr == 5'd3) found = 1'b1;
            else @(negedge CLK);
        end
        check("abort reached beat 3", found, 1'b1);
        m_if.m_ready = 1'b0; abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort beat held valid", m_if.m_valid, 1'b1);
        check("abort beat held addr",  m_if.m_addr, 5'd3);
        @(negedge CLK);
        check("abort beat still valid", m_if.m_valid, 1'b1);
        m_if.m_ready = 1'b1;
        @(negedge CLK);
        check("abort valid after", m_if.m_valid, 1'b0);
        check("abort busy after",  busy, 1'b0);
        check("abort no done",     done, 1'b0);
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            if (m_if.m_valid || done || busy) bad = 1'b1;
        end
        check("abort no further beats", bad, 1'b0);

        // Abort during FETCH: back to IDLE with no beat.
        @(negedge CLK);
        start = 1'b1; first_addr = 5'd4; last_addr = 5'd6;
        @(negedge CLK);
        start = 1'b0; abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("fetch abort busy",  busy, 1'b0);
        check("fetch abort valid", m_if.m_valid, 1'b0);
        bad = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge CLK);
            if (m_if.m_valid || done) bad = 1'b1;
        end
        check("fetch abort quiet", bad, 1'b0);

        // Start and abort together are ignored.
        @(negedge CLK);
        start = 1'b1; abort = 1'b1; first_addr = 5'd0; last_addr = 5'd3;
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        check("start+abort ignored", busy, 1'b0);

        // Write coherency: x9 written before the dump, x7 written on its FETCH edge.
        write_reg(5'd9, 32'h0000_0099);
        @(negedge CLK);
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd31; m_if.m_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        fin = 1'b0; wrote = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            if (k > 0) @(negedge CLK);
            we = 1'b0;
            if (busy && !m_if.m_valid && rf_addr == 5'd7 && !wrote) begin
                we = 1'b1; wa = 5'd7; wd = 32'hDEAD_BEEF; wrote = 1'b1;
            end
            if (m_if.m_valid && m_if.m_addr == 5'd7) check("coherency beat 7 old value", m_if.m_data, 32'h1000_0007);
            if (m_if.m_valid && m_if.m_addr == 5'd9) check("coherency beat 9 new value", m_if.m_data, 32'h0000_0099);
            if (m_if.m_valid && m_if.m_last) fin = 1'b1;
        end
        we = 1'b0;
        check("coherency write injected", wrote, 1'b1);
        check("coherency finished", fin, 1'b1);
        exp_mem[7] = 32'hDEAD_BEEF;
        repeat (2) @(negedge CLK);
        run_dump(5'd7, 5'd7, 1, "post-write x7");

        // Reset during SEND of beat 12, then a fresh dump.
        @(negedge CLK);
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd31; m_if.m_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            if (m_if.m_valid && m_if.m_addr == 5'd12) found = 1'b1;
            else @(negedge CLK);
        end
        check("reset reached beat 12", found, 1'b1);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        check("mid reset m_valid", m_if.m_valid, 1'b0);
        check("mid reset busy",    busy, 1'b0);
        check("mid reset m_addr",  m_if.m_addr, 5'd0);
        check("mid reset m_data",  m_if.m_data, 32'd0);
        check("mid reset rf_addr", rf_addr, 5'd0);
        check("mid reset done",    done, 1'b0);
        run_dump(5'd20, 5'd22, 3, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_dump_reader
